// File: rtl/instruction_cache_pkg.sv
// rtl/instruction_cache_pkg.sv - shared cache FSM encodings, block geometry and word-select helper
// Purpose: common definitions used by both the instruction and data caches.
// Ports: none (package).
package instruction_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_FETCH = 2'd1,
    UPDATE    = 2'd2
  } cache_state_t;

  localparam int BLOCK_BYTES   = 16;
  localparam int BLOCK_BITS    = BLOCK_BYTES * 8;
  localparam int MEM_ADDR_BITS = 28;

  // Word 0 lives in bits [31:0], word 3 in bits [127:96].
  function automatic logic [31:0] block_word(input logic [BLOCK_BITS-1:0] blk,
                                             input logic [1:0] offset);
    return blk[32*offset +: 32];
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// rtl/icache_line_array.sv - direct-mapped line storage: valid/tag/data with async read, sync write
// Purpose: per-line valid bit, tag and 128-bit block for the instruction cache.
// Ports:
//   clock      - single clock
//   reset      - synchronous active-high; clears valid bits only, blocks writes
//   rd_index   - line selected for the combinational read
//   rd_valid   - valid bit of the selected line
//   rd_tag     - tag of the selected line
//   rd_data    - data block of the selected line
//   wr_en      - write the line at wr_index on the next posedge
//   wr_index   - line to write
//   wr_tag     - tag to store
//   wr_data    - block to store
module icache_line_array
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 25
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags [LINES];
  logic [BLOCK_BITS-1:0] data [LINES];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data are never reset; a reset edge still suppresses the write so an
  // aborted fill leaves no trace in the arrays.
  always_ff @(posedge clock) begin
    if (wr_en && !reset) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache with single-block refill
// Purpose: zero-latency hits; a miss stalls the CPU, fetches a 16-byte block, installs it.
// Ports:
//   CLOCK        - single clock
//   RESET        - synchronous active-high reset
//   READ         - CPU fetch request
//   ADDRESS      - CPU byte PC (bits [1:0] ignored)
//   INSTRUCTION  - fetched instruction word
//   BUSYWAIT     - CPU stall
//   MEM_READ     - block read request to instruction memory
//   MEM_ADDRESS  - block address (PC[31:4]) of the fill in progress
//   MEM_READDATA - 16-byte block from memory
//   MEM_BUSYWAIT - memory busy; block valid when low
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int ADDR_BITS  = 32
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     READ,
  input  logic [ADDR_BITS-1:0]     ADDRESS,
  output logic [31:0]              INSTRUCTION,
  output logic                     BUSYWAIT,
  output logic                     MEM_READ,
  output logic [MEM_ADDR_BITS-1:0] MEM_ADDRESS,
  input  logic [BLOCK_BITS-1:0]    MEM_READDATA,
  input  logic                     MEM_BUSYWAIT
);

  localparam int TAG_BITS = ADDR_BITS - 4 - INDEX_BITS;

  cache_state_t state, next_state;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;

  logic                  line_valid;
  logic [TAG_BITS-1:0]   line_tag;
  logic [BLOCK_BITS-1:0] line_data;

  // Block address latched on the miss edge; drives memory and the fill target.
  logic [ADDR_BITS-5:0]  fill_block;
  logic [BLOCK_BITS-1:0] fill_data;
  logic                  line_write;

  logic unused_byte_bits;
  assign unused_byte_bits = ^ADDRESS[1:0];

  assign offset = ADDRESS[3:2];
  assign index  = ADDRESS[4+INDEX_BITS-1:4];
  assign tag    = ADDRESS[ADDR_BITS-1:4+INDEX_BITS];

  icache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .clock    (CLOCK),
    .reset    (RESET),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (line_write),
    .wr_index (fill_block[INDEX_BITS-1:0]),
    .wr_tag   (fill_block[ADDR_BITS-5:INDEX_BITS]),
    .wr_data  (fill_data)
  );

  assign hit         = line_valid && (line_tag == tag);
  assign INSTRUCTION = block_word(line_data, offset);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= IDLE;
      fill_block <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && READ && !hit) begin
        fill_block <= ADDRESS[ADDR_BITS-1:4];
      end
    end
  end

  // Capture the block on the edge that leaves MEM_FETCH; UPDATE writes it.
  always_ff @(posedge CLOCK) begin
    if (state == MEM_FETCH && !MEM_BUSYWAIT) begin
      fill_data <= MEM_READDATA;
    end
  end

  always_comb begin
    next_state  = state;
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    line_write  = 1'b0;
    case (state)
      IDLE: begin
        BUSYWAIT = READ && !hit;
        if (READ && !hit) begin
          next_state = MEM_FETCH;
        end
      end
      MEM_FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = MEM_ADDR_BITS'(fill_block);
        if (!MEM_BUSYWAIT) begin
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        BUSYWAIT   = 1'b1;
        line_write = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: doc/instruction_cache.md
INSTRUCTION_CACHE -- requirements
Module: instruction_cache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 3, giving 2^INDEX_BITS direct-mapped lines.
REQ-002 SHALL have parameter ADDR_BITS, default 32, giving the CPU PC width.
REQ-003 SHALL have port CLOCK  input  1  the single clock; all state updates on posedge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port READ  input  1  CPU fetch request.
REQ-006 SHALL have port ADDRESS  input  ADDR_BITS  CPU byte PC; bits [1:0] ignored.
REQ-007 SHALL have port INSTRUCTION  output  32  fetched instruction word.
REQ-008 SHALL have port BUSYWAIT  output  1  CPU stall request.
REQ-009 SHALL have port MEM_READ  output  1  block-read request to instruction memory.
REQ-010 SHALL have port MEM_ADDRESS  output  28  block address to memory (PC[31:4]).
REQ-011 SHALL have port MEM_READDATA  input  128  16-byte block from memory; byte 0 in bits [7:0].
REQ-012 SHALL have port MEM_BUSYWAIT  input  1  memory busy; block valid when it drops.

Function
REQ-013 SHALL decode offset = ADDRESS[3:2], index = ADDRESS[4+INDEX_BITS-1:4], tag = ADDRESS[ADDR_BITS-1:4+INDEX_BITS].
REQ-014 SHALL store per line: valid bit, tag, and 128-bit data block.
REQ-015 SHALL compute hit combinationally as valid[index] AND tag match.
REQ-016 SHALL drive INSTRUCTION combinationally from data[index] word selected by offset: offset 0 = bits [31:0], 3 = bits [127:96].
REQ-017 SHALL drive BUSYWAIT = READ AND NOT hit in IDLE, and 1 in MEM_FETCH and UPDATE.
REQ-018 SHALL return a hit with zero added latency: INSTRUCTION valid and BUSYWAIT low in the same cycle as READ.
REQ-019 SHALL implement states IDLE, MEM_FETCH, and UPDATE.
REQ-020 SHALL transition IDLE->MEM_FETCH on a posedge where READ is 1 and hit is 0; otherwise SHALL stay in IDLE.
REQ-021 SHALL, in MEM_FETCH, assert MEM_READ=1 and MEM_ADDRESS=ADDRESS[31:4]; MEM_READ SHALL be 0 and MEM_ADDRESS SHALL be 0 in other states.
REQ-022 SHALL transition MEM_FETCH->UPDATE on a posedge where MEM_BUSYWAIT is 0; the block SHALL be captured from MEM_READDATA at that edge.
REQ-023 SHALL, in UPDATE, write data, tag, and valid=1 to the indexed line at the next posedge, then transition to IDLE.
REQ-024 SHALL give a miss a total penalty of memory latency + 2 cycles; the refetch then hits in IDLE.
REQ-025 SHALL require the CPU to hold ADDRESS stable while BUSYWAIT=1; the fill SHALL use the MEM_FETCH-entry address latched at the IDLE->MEM_FETCH edge.
REQ-026 SHALL complete an in-flight fill if READ deasserts during MEM_FETCH; no request SHALL be dropped or duplicated.
REQ-027 SHALL replace a conflicting line (same index, different tag) unconditionally; there is no write path and no dirty state.

Reset
REQ-028 SHALL, on a posedge with RESET=1, clear all valid bits, set state to IDLE, and clear the latched fill address.
REQ-029 SHALL, after reset, drive MEM_READ=0 and MEM_ADDRESS=0, and drive BUSYWAIT=READ (all lines miss).
REQ-030 SHALL treat RESET in MEM_FETCH/UPDATE as an abort: the line is not written, and MEM_READ drops in the cycle after the reset edge.
REQ-031 SHALL leave data/tag arrays uninitialised by reset; only valid bits matter.

Structure
REQ-032 SHALL place state encodings (IDLE=2'd0, MEM_FETCH=2'd1, UPDATE=2'd2), block size (16 bytes), and MEM_ADDRESS width (28) in a shared package/header also used by the data cache.
REQ-033 SHALL split storage into one sub-module, icache_line_array: valid/tag/data arrays with combinational read and a synchronous write port.
REQ-034 SHALL keep the FSM, hit logic, and word select in instruction_cache.

Verification
REQ-035 SHALL verify cold miss: after reset, READ=1 with ADDRESS=0x00000000 -> BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=0; memory returns a block with word0=0x8F108093 -> INSTRUCTION=0x8F108093 and BUSYWAIT=0 at latency+2 cycles.
REQ-036 SHALL verify same-block hit: ADDRESS=0x0000000C after that fill -> BUSYWAIT=0 in the same cycle, INSTRUCTION=word3 of the block, MEM_READ stays 0.
REQ-037 SHALL verify conflict eviction: fill 0x00000000, then read 0x00000080 (same index 0, new tag) -> miss with MEM_ADDRESS=0x0000008; re-read 0x00000000 -> miss again.
REQ-038 SHALL verify reset mid-fill: RESET=1 while in MEM_FETCH -> MEM_READ=0 the next cycle, and a re-read of the same address misses.
REQ-039 SHALL verify READ drop during a fill: READ=0 mid-MEM_FETCH -> the fill completes, and a later READ of that address hits with no MEM_READ.
REQ-040 SHALL verify a slow memory: MEM_BUSYWAIT held high for 10 cycles -> the FSM stays in MEM_FETCH with MEM_READ=1 and a stable MEM_ADDRESS throughout.
